// File: rtl/adder_cmd_sequencer.sv
// rtl/adder_cmd_sequencer.sv - UART byte-stream sequencer for the shared adder bank
// Optional inter-byte timeout in the LOAD states: define ADDSEQ_TIMEOUT_EN.
module adder_cmd_sequencer #(
  parameter int W       = 64,
  parameter int ADD_LAT = 2,
  parameter int TO_CYC  = 100000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_rx_valid,
  input  logic [7:0]   i_rx_data,
  input  logic         i_tx_ready,
  output logic         o_tx_valid,
  output logic [7:0]   o_tx_data,
  output logic [1:0]   o_op_sel,
  output logic [W-1:0] o_op_a,
  output logic [W-1:0] o_op_b,
  output logic         o_op_start,
  input  logic [W:0]   i_sum_in,
  output logic         o_busy,
  output logic         o_overrun
);

  localparam int NB_OP = W / 8;
  localparam int NB_TX = (W + 8) / 8;
  localparam int IW    = (NB_TX > 1) ? $clog2(NB_TX) : 1;
  localparam int LW    = $clog2(ADD_LAT + 1);
  localparam int PADW  = 8 * NB_TX - (W + 1);

  localparam logic [IW-1:0] IDX_LAST_OP = IW'(NB_OP - 1);
  localparam logic [IW-1:0] IDX_LAST_TX = IW'(NB_TX - 1);
  localparam logic [LW-1:0] LAT_END     = LW'(ADD_LAT);
  localparam logic [7:0]    ERR_BYTE    = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_SEND,
    S_SEND_ERR
  } state_t;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [LW-1:0]  r_lat;
  logic [1:0]     r_op_sel;
  logic [W-1:0]   r_op_a;
  logic [W-1:0]   r_op_b;
  logic [W:0]     r_result;
  logic           r_tx_valid;
  logic [7:0]     r_tx_data;
  logic           r_op_start;
  logic           r_overrun;

  state_t         w_state_nx;
  logic [IW-1:0]  w_idx_nx;
  logic [LW-1:0]  w_lat_nx;
  logic [1:0]     w_op_sel_nx;
  logic [W-1:0]   w_op_a_nx;
  logic [W-1:0]   w_op_b_nx;
  logic [W:0]     w_result_nx;
  logic           w_tx_valid_nx;
  logic [7:0]     w_tx_data_nx;
  logic           w_op_start_nx;
  logic           w_overrun_nx;

  logic [IW-1:0]       w_idx_inc;
  logic [8*NB_TX-1:0]  w_res_pad;
  logic                w_tx_fire;
  logic                w_opcode_ok;

  assign w_idx_inc   = r_idx + IW'(1);
  assign w_res_pad   = {{PADW{1'b0}}, r_result};
  assign w_tx_fire   = r_tx_valid && i_tx_ready;
  assign w_opcode_ok = (i_rx_data[7:2] == 6'd0) && (i_rx_data[1:0] != 2'b11);

`ifdef ADDSEQ_TIMEOUT_EN
  localparam int TOW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TOW-1:0] TO_END = TOW'(TO_CYC - 1);
  logic [TOW-1:0] r_to_cnt;
  logic [TOW-1:0] w_to_nx;
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_idx_nx      = r_idx;
    w_lat_nx      = r_lat;
    w_op_sel_nx   = r_op_sel;
    w_op_a_nx     = r_op_a;
    w_op_b_nx     = r_op_b;
    w_result_nx   = r_result;
    w_tx_valid_nx = r_tx_valid;
    w_tx_data_nx  = r_tx_data;
    w_op_start_nx = 1'b0;
    w_overrun_nx  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (w_opcode_ok) begin
            w_op_sel_nx = i_rx_data[1:0];
            w_idx_nx    = '0;
            w_state_nx  = S_LOAD_A;
          end else begin
            w_tx_valid_nx = 1'b1;
            w_tx_data_nx  = ERR_BYTE;
            w_state_nx    = S_SEND_ERR;
          end
        end
      end
      S_LOAD_A: begin
        if (i_rx_valid) begin
          for (int k = 0; k < NB_OP; k++)
            if (r_idx == IW'(k)) w_op_a_nx[8*k +: 8] = i_rx_data;
          if (r_idx == IDX_LAST_OP) begin
            w_idx_nx   = '0;
            w_state_nx = S_LOAD_B;
          end else begin
            w_idx_nx = w_idx_inc;
          end
        end
      end
      S_LOAD_B: begin
        if (i_rx_valid) begin
          for (int k = 0; k < NB_OP; k++)
            if (r_idx == IW'(k)) w_op_b_nx[8*k +: 8] = i_rx_data;
          if (r_idx == IDX_LAST_OP) begin
            w_idx_nx      = '0;
            w_lat_nx      = '0;
            w_op_start_nx = 1'b1;
            w_state_nx    = S_EXEC;
          end else begin
            w_idx_nx = w_idx_inc;
          end
        end
      end
      S_EXEC: begin
        w_overrun_nx = i_rx_valid;
        // Byte 0 comes straight from sum_in since the result register loads on this same edge.
        if (r_lat == LAT_END) begin
          w_result_nx   = i_sum_in;
          w_idx_nx      = '0;
          w_tx_valid_nx = 1'b1;
          w_tx_data_nx  = i_sum_in[7:0];
          w_state_nx    = S_SEND;
        end else begin
          w_lat_nx = r_lat + LW'(1);
        end
      end
      S_SEND: begin
        w_overrun_nx = i_rx_valid;
        if (w_tx_fire) begin
          if (r_idx == IDX_LAST_TX) begin
            w_tx_valid_nx = 1'b0;
            w_idx_nx      = '0;
            w_state_nx    = S_IDLE;
          end else begin
            w_idx_nx = w_idx_inc;
            for (int k = 0; k < NB_TX; k++)
              if (w_idx_inc == IW'(k)) w_tx_data_nx = w_res_pad[8*k +: 8];
          end
        end
      end
      S_SEND_ERR: begin
        w_overrun_nx = i_rx_valid;
        if (w_tx_fire) begin
          w_tx_valid_nx = 1'b0;
          w_state_nx    = S_IDLE;
        end
      end
      default: begin
        w_tx_valid_nx = 1'b0;
        w_state_nx    = S_IDLE;
      end
    endcase

`ifdef ADDSEQ_TIMEOUT_EN
    w_to_nx = '0;
    if ((r_state == S_LOAD_A || r_state == S_LOAD_B) && !i_rx_valid) begin
      if (r_to_cnt == TO_END) begin
        w_idx_nx      = '0;
        w_tx_valid_nx = 1'b1;
        w_tx_data_nx  = ERR_BYTE;
        w_state_nx    = S_SEND_ERR;
      end else begin
        w_to_nx = r_to_cnt + TOW'(1);
      end
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_lat      <= '0;
      r_op_sel   <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_op_start <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_lat      <= w_lat_nx;
      r_op_sel   <= w_op_sel_nx;
      r_op_a     <= w_op_a_nx;
      r_op_b     <= w_op_b_nx;
      r_result   <= w_result_nx;
      r_tx_valid <= w_tx_valid_nx;
      r_tx_data  <= w_tx_data_nx;
      r_op_start <= w_op_start_nx;
      r_overrun  <= w_overrun_nx;
    end
  end

`ifdef ADDSEQ_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_to_cnt <= '0;
    else        r_to_cnt <= w_to_nx;
  end
`endif

  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;
  assign o_op_sel   = r_op_sel;
  assign o_op_a     = r_op_a;
  assign o_op_b     = r_op_b;
  assign o_op_start = r_op_start;
  assign o_busy     = (r_state != S_IDLE);
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_adder_cmd_sequencer.sv
// tb/tb_adder_cmd_sequencer.sv - directed bench for adder_cmd_sequencer
module tb_adder_cmd_sequencer;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         tx_ready;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic [1:0]   op_sel;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_start;
  logic [W:0]   sum_in;
  logic         busy;
  logic         overrun;

  int checks = 0;
  int errors = 0;
  logic [71:0] got;
  logic [71:0] exp_v;
  logic [7:0]  b0;

  always #5 clk = ~clk;

  // Stand-in for the external adder bank
  assign sum_in = {1'b0, op_a} + {1'b0, op_b};

  adder_cmd_sequencer #(.W(W), .ADD_LAT(2), .TO_CYC(50)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .i_tx_ready (tx_ready),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .o_op_sel   (op_sel),
    .o_op_a     (op_a),
    .o_op_b     (op_b),
    .o_op_start (op_start),
    .i_sum_in   (sum_in),
    .o_busy     (busy),
    .o_overrun  (overrun)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    send_byte(op);
    for (int i = 0; i < 8; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 8; i++) send_byte(b[8*i +: 8]);
  endtask

  task automatic wait_tx(input string tag);
    int g = 0;
    while (!tx_valid && g < 100) begin
      tick();
      g++;
    end
    check(tag, tx_valid, 1);
  endtask

  task automatic recv(output logic [71:0] r, input int n, input int stall);
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < n; i++) begin
      wait_tx("tx_valid_wait");
      b = tx_data;
      for (int s = 0; s < stall; s++) begin
        tx_ready = 1'b0;
        tick();
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, b);
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      r[8*i +: 8] = b;
    end
  endtask

  task automatic cmp_bytes(input string tag, input logic [71:0] r, input logic [71:0] e);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s_byte%0d", tag, i), r[8*i +: 8], e[8*i +: 8]);
  endtask

  initial begin
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_valid = ~rx_valid;
      rx_data  = 8'h01;
      tick();
    end
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_op_sel", op_sel, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_op_start", op_start, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // RCA 1 + 2 with latency checks
    send_frame(8'h00, 64'h1, 64'h2);
    check("rca_op_start_hi", op_start, 1);
    check("rca_busy", busy, 1);
    tick();
    check("rca_op_start_lo", op_start, 0);
    tick();
    check("rca_no_tx_yet", tx_valid, 0);
    tick();
    check("rca_tx_up", tx_valid, 1);
    exp_v = 72'h00_0000_0000_0000_0003;
    recv(got, 9, 0);
    cmp_bytes("rca", got, exp_v);
    check("rca_idle", busy, 0);
    check("rca_tx_down", tx_valid, 0);

    // CLA with carry out
    send_frame(8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("cla_op_sel_exec", op_sel, 2'b01);
    recv(got, 9, 0);
    check("cla_op_sel_after", op_sel, 2'b01);
    exp_v = 72'h01_FFFF_FFFF_FFFF_FFFE;
    cmp_bytes("cla", got, exp_v);

    // Backpressure, 5 stalled cycles per byte
    send_frame(8'h00, 64'h1, 64'h2);
    recv(got, 9, 5);
    exp_v = 72'h00_0000_0000_0000_0003;
    cmp_bytes("bp", got, exp_v);

    // Invalid opcodes
    send_byte(8'h03);
    check("inv03_valid", tx_valid, 1);
    check("inv03_data", tx_data, 8'hEE);
    check("inv03_busy", busy, 1);
    recv(got, 1, 2);
    check("inv03_byte", got[7:0], 8'hEE);
    check("inv03_idle", busy, 0);
    send_byte(8'h40);
    recv(got, 1, 0);
    check("inv40_byte", got[7:0], 8'hEE);
    check("inv40_idle", busy, 0);
    check("inv40_no_more", tx_valid, 0);

    // CSA frame right after the error bytes
    send_frame(8'h02, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    check("csa_op_sel", op_sel, 2'b10);
    recv(got, 9, 0);
    exp_v = 72'h00_1234_5678_9ABC_DF00;
    cmp_bytes("csa", got, exp_v);

    // Overrun while a byte is stalled in SEND
    send_frame(8'h00, 64'h1, 64'h2);
    wait_tx("ovr_tx_wait");
    b0 = tx_data;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    rx_valid = 1'b0;
    check("ovr_pulse", overrun, 1);
    check("ovr_data_held", tx_data, b0);
    check("ovr_busy", busy, 1);
    tick();
    check("ovr_pulse_end", overrun, 0);
    recv(got, 9, 0);
    exp_v = 72'h00_0000_0000_0000_0003;
    cmp_bytes("ovr", got, exp_v);

    // Reset after the 4th A byte
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_op_a", op_a, 0);
    check("mid_op_sel", op_sel, 0);
    check("mid_tx_valid", tx_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(8'h01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001);
    recv(got, 9, 1);
    exp_v = 72'h01_0000_0000_0000_0001;
    cmp_bytes("fresh", got, exp_v);
    check("fresh_idle", busy, 0);

`ifdef ADDSEQ_TIMEOUT_EN
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) send_byte(8'hB0 + 8'(i));
    repeat (40) tick();
    check("to_not_early", tx_valid, 0);
    wait_tx("to_tx_wait");
    check("to_err_byte", tx_data, 8'hEE);
    recv(got, 1, 0);
    check("to_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
